mac_result_buffer: RTL and testbench

//  Datapath stage driven by the neuron sequencing controller. Multiplies each x/w operand pair into a signed

---
 rtl/mac_result_buffer_pkg.sv | 36 +++
 rtl/mac_result_buffer_sync_fifo.sv | 47 ++++
 rtl/mac_result_buffer.sv | 102 ++++++++++
 tb/tb_mac_result_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_result_buffer_pkg.sv
// Shared helpers for the MAC result buffer: accumulator width derivation and
// the fixed-point scale/saturate used when a result is pushed.
package mac_pkg;

  localparam int MAX_W = 64;

  function automatic int acc_width(input int n, input int guard);
    return 2 * n + guard;
  endfunction

  // Arithmetic shift (floor) then clamp to the signed n-bit range.
  function automatic logic signed [MAX_W-1:0] sat_scale(input logic signed [MAX_W-1:0] acc,
                                                        input int frac, input int n);
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] s;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    one = 1;
    s   = acc >>> frac;
    hi  = (one <<< (n - 1)) - one;
    lo  = -(one <<< (n - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic logic scale_saturates(input logic signed [MAX_W-1:0] acc,
                                           input int frac, input int n);
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] s;
    one = 1;
    s   = acc >>> frac;
    return (s > ((one <<< (n - 1)) - one)) || (s < -(one <<< (n - 1)));
  endfunction

endpackage

// File: rtl/mac_result_buffer_sync_fifo.sv
// Show-ahead synchronous FIFO. The caller must never push while full unless
// it pops in the same cycle; overflow policy lives outside.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign head  = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/mac_result_buffer.sv
// MAC accumulator with scale/saturate on result write, feeding a show-ahead
// result FIFO, with sticky error flags and end-of-batch tracking.
import mac_pkg::*;

module mac_result_buffer #(
  parameter int N     = 8,
  parameter int FRAC  = N - 1,
  parameter int GUARD = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc_write,
  input  logic                   clear_acc,
  input  logic                   res_write,
  input  logic                   done,
  input  logic [N-1:0]           x_in,
  input  logic [N-1:0]           w_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   sat_err,
  output logic                   ovf_err,
  output logic                   batch_done
);
  localparam int ACC_W = acc_width(N, GUARD);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic signed [2*N-1:0]   product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [MAX_W-1:0] acc_wide;
  logic [N-1:0]            result;
  logic                    result_sat;
  logic                    full;
  logic                    empty;
  logic                    push_ok;
  logic                    pop;
  logic [CW-1:0]           count_next;
  logic                    done_seen_reg;
  logic                    done_seen_next;
  logic                    sat_err_reg;
  logic                    ovf_err_reg;
  logic                    batch_done_reg;

  assign product     = $signed(x_in) * $signed(w_in);
  assign product_ext = {{GUARD{product[2*N-1]}}, product};

  // Clear-and-accumulate together loads the product directly.
  always_comb begin
    acc_next = acc_reg;
    if (clear_acc && acc_write) acc_next = product_ext;
    else if (clear_acc)         acc_next = '0;
    else if (acc_write)         acc_next = acc_reg + product_ext;
  end

  assign acc_wide   = {{(MAX_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
  assign result     = N'(sat_scale(acc_wide, FRAC, N));
  assign result_sat = scale_saturates(acc_wide, FRAC, N);

  assign pop        = out_valid & out_ready;
  assign push_ok    = res_write & (~full | pop);
  assign count_next = count + CW'(push_ok) - CW'(pop);

  assign done_seen_next = done | (done_seen_reg & ~push_ok);

  sync_fifo #(.W(N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (result),
    .head  (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg        <= '0;
      done_seen_reg  <= 1'b0;
      sat_err_reg    <= 1'b0;
      ovf_err_reg    <= 1'b0;
      batch_done_reg <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      done_seen_reg  <= done_seen_next;
      batch_done_reg <= done_seen_next & (count_next == '0);
      if (push_ok & result_sat)    sat_err_reg <= 1'b1;
      if (res_write & full & ~pop) ovf_err_reg <= 1'b1;
    end
  end

  assign out_valid  = ~empty;
  assign sat_err    = sat_err_reg;
  assign ovf_err    = ovf_err_reg;
  assign batch_done = batch_done_reg;

endmodule

// File: tb/tb_mac_result_buffer.sv
// Directed bench for mac_result_buffer with a queue-based reference model
// checked every cycle, plus literal expectations for the key vectors.
module tb_mac_result_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       acc_write = 1'b0;
  logic       clear_acc = 1'b0;
  logic       res_write = 1'b0;
  logic       done = 1'b0;
  logic [7:0] x_in = '0;
  logic [7:0] w_in = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       sat_err;
  logic       ovf_err;
  logic       batch_done;

  int total = 0;
  int bad = 0;

  mac_result_buffer #(.N(8), .FRAC(7), .GUARD(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_write  (acc_write),
    .clear_acc  (clear_acc),
    .res_write  (res_write),
    .done       (done),
    .x_in       (x_in),
    .w_in       (w_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .count      (count),
    .sat_err    (sat_err),
    .ovf_err    (ovf_err),
    .batch_done (batch_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer accumulator, queue of results, plain flags.
  longint m_acc = 0;
  int     q[$];
  bit     m_sat = 0, m_ovf = 0, m_ds = 0, m_bd = 0;
  bit     started = 0;

  function automatic longint wrap20(input longint v);
    longint m;
    m = v & 64'h00000000000FFFFF;
    if (m >= 524288) m = m - 1048576;
    return m;
  endfunction

  always @(posedge clk) begin
    longint s;
    int     r;
    bit     satf, do_pop, is_full;
    started = 1;
    if (rst) begin
      m_acc = 0;
      q.delete();
      m_sat = 0; m_ovf = 0; m_ds = 0; m_bd = 0;
    end else begin
      s = m_acc >>> 7;
      satf = 1;
      if (s > 127)       r = 127;
      else if (s < -128) r = -128;
      else begin r = int'(s); satf = 0; end
      do_pop  = (q.size() != 0) && out_ready;
      is_full = (q.size() == 4);
      if (res_write && is_full && !do_pop) m_ovf = 1;
      else begin
        if (do_pop) void'(q.pop_front());
        if (res_write) begin
          q.push_back(r);
          if (satf) m_sat = 1;
          m_ds = 0;
        end
      end
      if (done) m_ds = 1;
      if (clear_acc) m_acc = 0;
      if (acc_write) m_acc = wrap20(m_acc + longint'($signed(x_in)) * longint'($signed(w_in)));
      m_bd = m_ds && (q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", int'(out_valid), int'(q.size() != 0));
      chk("m_data", int'($signed(out_data)), (q.size() != 0) ? q[0] : 0);
      chk("m_count", int'(count), q.size());
      chk("m_sat", int'(sat_err), int'(m_sat));
      chk("m_ovf", int'(ovf_err), int'(m_ovf));
      chk("m_bdone", int'(batch_done), int'(m_bd));
    end
  end

  task automatic step(input bit aw, input bit cl, input bit rw, input bit dn, input bit rdy,
                      input int x = 0, input int w = 0);
    acc_write = aw; clear_acc = cl; res_write = rw; done = dn; out_ready = rdy;
    x_in = 8'(x); w_in = 8'(w);
    @(posedge clk); #1;
    $display("step rst=%0b aw=%0b cl=%0b rw=%0b dn=%0b rdy=%0b x=%0d w=%0d -> valid=%0b data=%0d count=%0d sat=%0b ovf=%0b bdone=%0b",
             rst, aw, cl, rw, dn, rdy, x, w, out_valid, $signed(out_data), count, sat_err, ovf_err, batch_done);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_flags", int'({sat_err, ovf_err, batch_done}), 0);
    rst = 1'b0;

    // 2 x (64*64) = 8192 -> 64
    step(0, 1, 0, 0, 1);
    repeat (2) step(1, 0, 0, 0, 1, 64, 64);
    step(0, 0, 1, 0, 1);
    chk("t1_data", int'($signed(out_data)), 64);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_sat", int'(sat_err), 0);
    step(0, 0, 0, 0, 1);

    // 4 x (64*64) = 16384 -> saturates to 127
    step(0, 1, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0, 1, 64, 64);
    step(0, 0, 1, 0, 1);
    chk("t2_data", int'($signed(out_data)), 127);
    chk("t2_sat", int'(sat_err), 1);
    step(0, 0, 0, 0, 1);

    // -128*127 = -16256 -> -127
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1, -128, 127);
    step(0, 0, 1, 0, 1);
    chk("t3_data", int'($signed(out_data)), -127);
    step(0, 0, 0, 0, 1);

    // -128*-128 = 16384 -> 127
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1, -128, -128);
    step(0, 0, 1, 0, 1);
    chk("t4_data", int'($signed(out_data)), 127);
    step(0, 0, 0, 0, 1);

    // Overflow: pushes 1..5 with consumer stalled, 5th dropped
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 64, 2);
    repeat (5) step(1, 0, 1, 0, 0, 64, 2);
    chk("t5_count", int'(count), 4);
    chk("t5_ovf", int'(ovf_err), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("t5_drain", int'($signed(out_data)), k);
      step(0, 0, 0, 0, 1);
    end
    chk("t5_empty", int'(count), 0);
    // Refill with 6..9, then push 10 while popping 6 at full
    repeat (4) step(1, 0, 1, 0, 0, 64, 2);
    step(0, 0, 1, 0, 1);
    chk("t5_fullpp", int'(count), 4);
    for (int k = 7; k <= 10; k++) begin
      chk("t5_drain2", int'($signed(out_data)), k);
      step(0, 0, 0, 0, 1);
    end

    // Clear+accumulate: 500 -> 6, then +122 = 128 -> 1
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1, 20, 25);
    step(1, 1, 0, 0, 1, 2, 3);
    step(1, 0, 0, 0, 1, 61, 2);
    step(0, 0, 1, 0, 1);
    chk("t6_data", int'($signed(out_data)), 1);
    step(0, 0, 0, 0, 1);

    // Batch done with two queued entries
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 64, 2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t7_bd_queued", int'(batch_done), 0);
    step(0, 0, 0, 0, 1);
    chk("t7_bd_pop1", int'(batch_done), 0);
    step(0, 0, 0, 0, 1);
    chk("t7_bd_pop2", int'(batch_done), 1);
    step(0, 0, 1, 0, 0);
    chk("t7_bd_push", int'(batch_done), 0);
    step(0, 0, 1, 0, 0);
    chk("t7_count", int'(count), 2);
    rst = 1'b1;
    step(0, 0, 0, 0, 1);
    rst = 1'b0;
    chk("t7_rst_valid", int'(out_valid), 0);
    chk("t7_rst_count", int'(count), 0);
    chk("t7_rst_data", int'(out_data), 0);
    chk("t7_rst_flags", int'({sat_err, ovf_err, batch_done}), 0);
    step(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
